// File: rtl/ping_pong_pkg.sv
// rtl/ping_pong_pkg.sv - glyph constants and select codes for the ping-pong counter display
package ping_pong_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SEG_UP    = 7'b0100011;
  localparam logic [6:0] SEG_DOWN  = 7'b0011100;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    GLYPH_DIGIT = 2'd0,
    GLYPH_UP    = 2'd1,
    GLYPH_DOWN  = 2'd2,
    GLYPH_BLANK = 2'd3
  } glyph_sel_e;

endpackage

// File: rtl/seven_seg_encoder.sv
// rtl/seven_seg_encoder.sv - combinational decimal/direction glyph encoder, active-high output
module seven_seg_encoder
  import ping_pong_pkg::*;
(
  input  logic [3:0]  code_i,
  input  glyph_sel_e  sel_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (sel_i)
      GLYPH_DIGIT: if (code_i <= 4'd9) seg_o = SEG_DIGIT[code_i];
      GLYPH_UP:    seg_o = SEG_UP;
      GLYPH_DOWN:  seg_o = SEG_DOWN;
      GLYPH_BLANK: seg_o = SEG_BLANK;
      default:     seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ping_pong_seven_seg_display.sv
// rtl/ping_pong_seven_seg_display.sv - 4-digit multiplexed display of ping-pong counter value and direction
module ping_pong_seven_seg_display
  import ping_pong_pkg::*;
#(
  parameter int DIV_BITS = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            value,
  input  logic                  direction,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [DIV_BITS-1:0]   prescaler_q, prescaler_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            snap_val_q, snap_val_d;
  logic                  snap_dir_q, snap_dir_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  tick;
  logic [3:0]            ones;
  logic [3:0]            enc_code;
  glyph_sel_e            enc_sel;
  logic [6:0]            enc_seg;

  assign tick        = &prescaler_q;
  assign prescaler_d = prescaler_q + DIV_BITS'(1);
  assign idx_d       = tick ? idx_q + IDX_W'(1) : idx_q;

  // Snapshot once per full scan so a scan never mixes two values
  assign snap_val_d = (tick && (&idx_q)) ? value     : snap_val_q;
  assign snap_dir_d = (tick && (&idx_q)) ? direction : snap_dir_q;

  assign ones = (snap_val_d >= 4'd10) ? snap_val_d - 4'd10 : snap_val_d;

  always_comb begin
    enc_code = 4'd0;
    enc_sel  = GLYPH_BLANK;
    case (idx_d)
      2'd0: begin
        enc_code = ones;
        enc_sel  = GLYPH_DIGIT;
      end
      2'd1: begin
        enc_code = 4'd1;
        enc_sel  = (snap_val_d >= 4'd10) ? GLYPH_DIGIT : GLYPH_BLANK;
      end
      default: enc_sel = snap_dir_d ? GLYPH_UP : GLYPH_DOWN;
    endcase
  end

  seven_seg_encoder u_encoder (
    .code_i (enc_code),
    .sel_i  (enc_sel),
    .seg_o  (enc_seg)
  );

  // Outputs are recomputed every cycle; their inputs only move on a tick or a blank change
  assign an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_d);
  assign seg_d = ~enc_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      snap_val_q  <= 4'd0;
      snap_dir_q  <= 1'b1;
      an_q        <= 4'b1110;
      seg_q       <= 7'b1000000;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      snap_val_q  <= snap_val_d;
      snap_dir_q  <= snap_dir_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_ping_pong_seven_seg_display.sv
// tb/tb_ping_pong_seven_seg_display.sv - directed self-checking bench for ping_pong_seven_seg_display
module tb_ping_pong_seven_seg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value = 4'd0;
  logic       direction = 1'b1;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ping_pong_seven_seg_display #(.DIV_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .direction (direction),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; stimulus and sampling both happen on the falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  // Run to the edge where idx wraps 3 -> 0 (16 edges per scan with DIV_BITS=2)
  task automatic to_wrap();
    step(16 - (cyc % 16));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    value = 4'd9;
    step(2);
    total++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      bad++;
      $display("FAIL reset_state an=%b seg=%b dp=%b want an=1110 seg=1000000 dp=1", an, seg, dp);
    end
    step(6);
    total++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      bad++;
      $display("FAIL reset_hold an=%b seg=%b want an=1110 seg=1000000", an, seg);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_scan_7_up();
    logic [3:0] exp_an [0:3];
    logic [6:0] exp_seg [0:3];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b1111000, 7'b1111111, 7'b1011100, 7'b1011100};
    value = 4'd7;
    direction = 1'b1;
    to_wrap();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step(4);
      total++;
      if ({an, seg, dp} !== {exp_an[i], exp_seg[i], 1'b1}) begin
        bad++;
        $display("FAIL scan7_idx%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                 i, an, seg, dp, exp_an[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_scan_13_down();
    logic [6:0] exp_seg [0:3];
    exp_seg = '{7'b0110000, 7'b1111001, 7'b1100011, 7'b1100011};
    value = 4'd13;
    direction = 1'b0;
    to_wrap();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step(4);
      total++;
      if (seg !== exp_seg[i]) begin
        bad++;
        $display("FAIL scan13_idx%0d seg=%b want %b", i, seg, exp_seg[i]);
      end
    end
  endtask

  task automatic test_midscan_change();
    value = 4'd4;
    direction = 1'b1;
    to_wrap();
    total++;
    if (seg !== 7'b0011001) begin
      bad++;
      $display("FAIL mid_idx0_4 seg=%b want 0011001", seg);
    end
    step(4);
    value = 4'd12;
    step(1);
    total++;
    if ({an, seg} !== {4'b1101, 7'b1111111}) begin
      bad++;
      $display("FAIL mid_idx1_still4 an=%b seg=%b want an=1101 seg=1111111", an, seg);
    end
    step(3);
    total++;
    if ({an, seg} !== {4'b1011, 7'b1011100}) begin
      bad++;
      $display("FAIL mid_idx2 an=%b seg=%b want an=1011 seg=1011100", an, seg);
    end
    step(7);
    total++;
    if ({an, seg} !== {4'b0111, 7'b1011100}) begin
      bad++;
      $display("FAIL mid_before_wrap an=%b seg=%b want an=0111 seg=1011100", an, seg);
    end
    step(1);
    total++;
    if ({an, seg} !== {4'b1110, 7'b0100100}) begin
      bad++;
      $display("FAIL mid_wrap_12 an=%b seg=%b want an=1110 seg=0100100", an, seg);
    end
    step(4);
    total++;
    if (seg !== 7'b1111001) begin
      bad++;
      $display("FAIL mid_idx1_12 seg=%b want 1111001", seg);
    end
  endtask

  task automatic test_blank();
    step((8 - (cyc % 16) + 16) % 16);
    blank = 1'b1;
    step(1);
    total++;
    if ({an, seg} !== {4'b1111, 7'b1011100}) begin
      bad++;
      $display("FAIL blank_on an=%b seg=%b want an=1111 seg=1011100", an, seg);
    end
    to_wrap();
    total++;
    if ({an, seg} !== {4'b1111, 7'b0100100}) begin
      bad++;
      $display("FAIL blank_scan an=%b seg=%b want an=1111 seg=0100100", an, seg);
    end
    blank = 1'b0;
    step(1);
    total++;
    if ({an, seg} !== {4'b1110, 7'b0100100}) begin
      bad++;
      $display("FAIL blank_off an=%b seg=%b want an=1110 seg=0100100", an, seg);
    end
  endtask

  task automatic test_reset_midscan();
    value = 4'd15;
    to_wrap();
    total++;
    if (seg !== 7'b0010010) begin
      bad++;
      $display("FAIL rst_mid_snap15 seg=%b want 0010010", seg);
    end
    step(8);
    total++;
    if (an !== 4'b1011) begin
      bad++;
      $display("FAIL rst_mid_at_idx2 an=%b want 1011", an);
    end
    rst = 1'b1;
    value = 4'd6;
    step(1);
    rst = 1'b0;
    cyc = 0;
    total++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      bad++;
      $display("FAIL rst_mid_state an=%b seg=%b want an=1110 seg=1000000", an, seg);
    end
    step(4);
    total++;
    if ({an, seg} !== {4'b1101, 7'b1111111}) begin
      bad++;
      $display("FAIL rst_mid_discard an=%b seg=%b want an=1101 seg=1111111", an, seg);
    end
    to_wrap();
    total++;
    if ({an, seg} !== {4'b1110, 7'b0000010}) begin
      bad++;
      $display("FAIL rst_mid_capture an=%b seg=%b want an=1110 seg=0000010", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan_7_up();
    test_scan_13_down();
    test_midscan_change();
    test_blank();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
